seq_mul: RTL and testbench

SEQ_MUL -- requirements
Module: seq_mul

---
 rtl/seq_mul.sv | 90 +++++++++
 tb/tb_seq_mul.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// Radix-2 shift-add multiplier: WIDTH iteration cycles plus a settle cycle, done pulses in DONE.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands (last iteration subtracts).
module seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     hi_ext, addend, sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // One extra bit on the upper half keeps the carry (or sign) of each partial sum.
  always_comb begin
`ifdef SEQ_MUL_SIGNED_EN
    hi_ext = {acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
    addend = b_q[0] ? {a_q[WIDTH-1], a_q} : '0;
    sum    = (cnt_q == CW'(1)) ? (hi_ext - addend) : (hi_ext + addend);
`else
    hi_ext = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    addend = b_q[0] ? {1'b0, a_q} : '0;
    sum    = hi_ext + addend;
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = acc_q;

endmodule

// File: tb/tb_seq_mul.sv
module tb_seq_mul;

`ifdef SEQ_MUL_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start16 = 1'b0, start4 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy16, done16, busy4, done4;
  logic [31:0] result16;
  logic [7:0]  result4;

  int total = 0;
  int fails = 0;

  seq_mul #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16)
  );

  seq_mul #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_u;
    logic [31:0] exp_s;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Starts one multiply; checks busy, latency (edges from accept to done), product,
  // return to idle, and over 'tail' further cycles: no extra done and result held.
  task automatic run_mul(input bit w4, input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] exp, input string nm, input int tail,
                         input bit repulse);
    int lat;
    int wd;
    int pulses;
    logic [31:0] res;
    wd = w4 ? 4 : 16;
    @(negedge clk);
    if (w4) begin start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; end
    else    begin start16 = 1'b1; a16 = av; b16 = bv; end
    @(posedge clk); #1;
    start4 = 1'b0; start16 = 1'b0;
    a16 = ~av; b16 = ~bv; a4 = ~av[3:0]; b4 = ~bv[3:0];
    chk({nm, "_busy"}, {63'd0, (w4 ? busy4 : busy16)}, 64'd1);
    lat = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      if (repulse && k == 3) begin
        start16 = 1'b1; a16 = 16'h00FF; b16 = 16'h0033;
      end else if (repulse && k == 4) begin
        start16 = 1'b0;
      end
      @(posedge clk); #1;
      if (w4 ? done4 : done16) lat = k;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(wd + 1));
    res = w4 ? {24'd0, result4} : result16;
    chk({nm, "_result"}, {32'd0, res}, {32'd0, exp});
    @(posedge clk); #1;
    chk({nm, "_idle"}, {62'd0, (w4 ? done4 : done16), (w4 ? busy4 : busy16)}, 64'd0);
    if (tail > 0) begin
      pulses = 0;
      for (int k = 0; k < tail; k++) begin
        @(posedge clk); #1;
        if (w4 ? done4 : done16) pulses++;
      end
      chk({nm, "_extra_done"}, 64'(pulses), 64'd0);
      res = w4 ? {24'd0, result4} : result16;
      chk({nm, "_hold"}, {32'd0, res}, {32'd0, exp});
    end
  endtask

  initial begin
    vec_t vt[8];
    vt[0] = '{16'h0001, 16'h0000, 32'h00000000, 32'h00000000};
    vt[1] = '{16'h0002, 16'h0001, 32'h00000002, 32'h00000002};
    vt[2] = '{16'h0002, 16'h0002, 32'h00000004, 32'h00000004};
    vt[3] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h00000001};
    vt[4] = '{16'h8000, 16'h0002, 32'h00010000, 32'hFFFF0000};
    vt[5] = '{16'h1234, 16'h5678, 32'h06260060, 32'h06260060};
    vt[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 32'hFFFFFFFF};
    vt[7] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001, 32'h3FFF0001};

    #2 rst = 1'b1;
    #1;
    chk("reset_busy16", {63'd0, busy16}, 64'd0);
    chk("reset_done16", {63'd0, done16}, 64'd0);
    chk("reset_result16", {32'd0, result16}, 64'd0);
    chk("reset_w4", {54'd0, busy4, done4, result4}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Consecutive table entries start in the cycle right after the previous DONE.
    for (int i = 0; i < 8; i++)
      run_mul(1'b0, vt[i].a, vt[i].b, SGN ? vt[i].exp_s : vt[i].exp_u,
              $sformatf("vec%0d", i), 0, 1'b0);

    run_mul(1'b0, 16'h0015, 16'h0010, 32'h00000150, "ignore_start", 25, 1'b1);

    // Abort mid-run with reset, then start on the first edge after release.
    @(negedge clk);
    start16 = 1'b1; a16 = 16'h1234; b16 = 16'h5678;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy16}, 64'd0);
    chk("abort_result", {32'd0, result16}, 64'd0);
    chk("abort_done", {63'd0, done16}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_mul(1'b0, 16'h0003, 16'h0005, 32'h0000000F, "after_reset", 20, 1'b0);

    run_mul(1'b1, 16'h000F, 16'h000F, SGN ? 32'h00000001 : 32'h000000E1, "w4_ff", 3, 1'b0);
    run_mul(1'b1, 16'h0008, 16'h0008, 32'h00000040, "w4_88", 3, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
